// File: rtl/traffic_light_monitor_if.sv
// Light buses from the intersection controller, one-hot per lamp: 100=red, 010=yellow, 001=green.
interface traffic_light_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;

  modport master (output light_M1, light_M2, light_MT, light_S);
  modport slave  (input  light_M1, light_M2, light_MT, light_S);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker on the intersection light buses: decodes the phase, times it, raises sticky faults.
// One register stage from bus sample to every output; purely observing, never stalls the controller.
module traffic_light_monitor #(
  parameter int DWELL_P0 = 8,
  parameter int DWELL_P1 = 3,
  parameter int DWELL_P2 = 6,
  parameter int DWELL_P3 = 3,
  parameter int DWELL_P4 = 4,
  parameter int DWELL_P5 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_light_monitor_if.slave lights,
  input  logic                   clr_faults,
  output logic [2:0]             phase,
  output logic [7:0]             dwell,
  output logic                   in_sync,
  output logic                   fault_pattern,
  output logic                   fault_sequence,
  output logic                   fault_timing,
  output logic                   fault_any,
  output logic [15:0]            cycle_count
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YEL    = 3'b010;
  localparam logic [2:0] GRN    = 3'b001;
  localparam logic [2:0] PH_BAD = 3'd7;

  typedef enum logic [1:0] {SEEK, ACQUIRE, TRACK} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] decoded;
  logic [2:0] phase_succ;
  logic [7:0] dwell_target;
  logic       changed;
  logic       is_succ;
  logic       set_pattern;
  logic       set_sequence;
  logic       set_timing;
  logic       inc_cycle;

  // Bus order in the match word is {M1, M2, MT, S}.
  always_comb begin
    decoded = PH_BAD;
    case ({lights.light_M1, lights.light_M2, lights.light_MT, lights.light_S})
      {GRN, GRN, RED, RED}: decoded = 3'd0;
      {GRN, YEL, RED, RED}: decoded = 3'd1;
      {GRN, RED, GRN, RED}: decoded = 3'd2;
      {YEL, RED, YEL, RED}: decoded = 3'd3;
      {RED, RED, RED, GRN}: decoded = 3'd4;
      {RED, RED, RED, YEL}: decoded = 3'd5;
      default:              decoded = PH_BAD;
    endcase
  end

  always_comb begin
    dwell_target = 8'd0;
    case (phase)
      3'd0:    dwell_target = 8'(DWELL_P0);
      3'd1:    dwell_target = 8'(DWELL_P1);
      3'd2:    dwell_target = 8'(DWELL_P2);
      3'd3:    dwell_target = 8'(DWELL_P3);
      3'd4:    dwell_target = 8'(DWELL_P4);
      3'd5:    dwell_target = 8'(DWELL_P5);
      default: dwell_target = 8'd0;
    endcase
  end

  assign phase_succ = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  assign changed    = (decoded != phase);
  assign is_succ    = (decoded == phase_succ);

  // Branch order gives pattern > sequence > timing when conditions coincide.
  always_comb begin
    state_nxt    = state;
    set_pattern  = 1'b0;
    set_sequence = 1'b0;
    set_timing   = 1'b0;
    inc_cycle    = 1'b0;
    if (decoded == PH_BAD) begin
      set_pattern = 1'b1;
      state_nxt   = SEEK;
    end else begin
      case (state)
        SEEK: state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (changed) begin
            if (is_succ) state_nxt = TRACK;
            else         set_sequence = 1'b1;
          end
        end
        TRACK: begin
          if (changed) begin
            if (!is_succ) begin
              set_sequence = 1'b1;
              state_nxt    = ACQUIRE;
            end else if (dwell != dwell_target) begin
              set_timing = 1'b1;
            end else if (phase == 3'd5) begin
              inc_cycle = 1'b1;
            end
          end else if (dwell == dwell_target) begin
            set_timing = 1'b1;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SEEK;
      phase          <= PH_BAD;
      dwell          <= 8'd0;
      in_sync        <= 1'b0;
      fault_pattern  <= 1'b0;
      fault_sequence <= 1'b0;
      fault_timing   <= 1'b0;
      fault_any      <= 1'b0;
      cycle_count    <= 16'd0;
    end else begin
      state   <= state_nxt;
      phase   <= decoded;
      in_sync <= (state_nxt == TRACK);
      if (!changed) begin
        if (dwell != 8'hFF) dwell <= dwell + 8'd1;
      end else begin
        dwell <= 8'd1;
      end
      fault_pattern  <= set_pattern  | (fault_pattern  & ~clr_faults);
      fault_sequence <= set_sequence | (fault_sequence & ~clr_faults);
      fault_timing   <= set_timing   | (fault_timing   & ~clr_faults);
      fault_any      <= set_pattern | set_sequence | set_timing |
                        ((fault_pattern | fault_sequence | fault_timing) & ~clr_faults);
      if (inc_cycle) cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios with literal pins, then randomized phase streams vs a reference model.
module tb_traffic_light_monitor;

  localparam int SEEKING = 0;
  localparam int ACQUIRING = 1;
  localparam int LOCKED = 2;

  // Phase durations and bus patterns {M1, M2, MT, S}, indexed by phase.
  localparam int DW [6] = '{8, 3, 6, 3, 4, 3};
  localparam logic [11:0] PAT [6] = '{
    12'b001_001_100_100,
    12'b001_010_100_100,
    12'b001_100_001_100,
    12'b010_100_010_100,
    12'b100_100_100_001,
    12'b100_100_100_010
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_faults = 1'b0;
  logic [2:0]  phase;
  logic [7:0]  dwell;
  logic        in_sync;
  logic        fault_pattern;
  logic        fault_sequence;
  logic        fault_timing;
  logic        fault_any;
  logic [15:0] cycle_count;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  int m_phase;
  int m_dwell;
  int m_mode;
  int m_cc;
  bit m_fp;
  bit m_fs;
  bit m_ft;

  traffic_light_monitor_if bus_if ();

  traffic_light_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .lights         (bus_if),
    .clr_faults     (clr_faults),
    .phase          (phase),
    .dwell          (dwell),
    .in_sync        (in_sync),
    .fault_pattern  (fault_pattern),
    .fault_sequence (fault_sequence),
    .fault_timing   (fault_timing),
    .fault_any      (fault_any),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int decode(input logic [11:0] v);
    for (int i = 0; i < 6; i++) if (v == PAT[i]) return i;
    return 7;
  endfunction

  function automatic int dw_of(input int p);
    return (p >= 0 && p < 6) ? DW[p] : -1;
  endfunction

  function automatic logic [11:0] bus_now();
    return {bus_if.light_M1, bus_if.light_M2, bus_if.light_MT, bus_if.light_S};
  endfunction

  task automatic set_bus(input logic [11:0] v);
    bus_if.light_M1 = v[11:9];
    bus_if.light_M2 = v[8:6];
    bus_if.light_MT = v[5:3];
    bus_if.light_S  = v[2:0];
  endtask

  task automatic m_reset();
    m_phase = 7; m_dwell = 0; m_mode = SEEKING; m_cc = 0;
    m_fp = 0; m_fs = 0; m_ft = 0;
  endtask

  // Reference behaviour: one update per sampled bus value.
  task automatic m_step();
    int d;
    bit sp, ss, st, chg, nxt;
    d   = decode(bus_now());
    sp  = 0; ss = 0; st = 0;
    chg = (d != m_phase);
    nxt = (m_phase < 6) && (d == (m_phase + 1) % 6);
    if (d == 7) begin
      sp = 1; m_mode = SEEKING;
    end else if (m_mode == SEEKING) begin
      m_mode = ACQUIRING;
    end else if (chg && !nxt) begin
      ss = 1; m_mode = ACQUIRING;
    end else if (chg && m_mode == ACQUIRING) begin
      m_mode = LOCKED;
    end else if (chg) begin
      if (m_dwell != dw_of(m_phase)) st = 1;
      else if (d == 0) m_cc = (m_cc + 1) % 65536;
    end else if (m_mode == LOCKED && m_dwell == dw_of(m_phase)) begin
      st = 1;
    end
    m_dwell = chg ? 1 : ((m_dwell + 1 > 255) ? 255 : m_dwell + 1);
    m_phase = d;
    if (clr_faults) begin m_fp = 0; m_fs = 0; m_ft = 0; end
    m_fp = m_fp | sp;
    m_fs = m_fs | ss;
    m_ft = m_ft | st;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("phase", 32'(phase), 32'(m_phase));
        check("dwell", 32'(dwell), 32'(m_dwell));
        check("in_sync", 32'(in_sync), 32'(m_mode == LOCKED));
        check("fault_pattern", 32'(fault_pattern), 32'(m_fp));
        check("fault_sequence", 32'(fault_sequence), 32'(m_fs));
        check("fault_timing", 32'(fault_timing), 32'(m_ft));
        check("fault_any", 32'(fault_any), 32'(m_fp | m_fs | m_ft));
        check("cycle_count", 32'(cycle_count), 32'(m_cc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step_raw(input logic [11:0] v, input logic clr);
    @(negedge clk);
    set_bus(v);
    clr_faults = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int p, input int n);
    for (int i = 0; i < n; i++) step_raw(PAT[p], 1'b0);
  endtask

  task automatic run_loop();
    for (int p = 0; p < 6; p++) step(p, DW[p]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd7);
    check({tag, "_dwell"}, 32'(dwell), 32'd0);
    check({tag, "_in_sync"}, 32'(in_sync), 32'd0);
    check({tag, "_fault_any"}, 32'({fault_pattern, fault_sequence, fault_timing, fault_any}), 32'd0);
    check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
  endtask

  // Reset raised between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cur;
    int r;
    int len;
    logic [11:0] v;

    set_bus(PAT[0]);
    rst = 1'b1;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean loops: lock on the first phase 1, three wraps counted.
    step(0, 8);
    check("acq_in_sync", 32'(in_sync), 32'd0);
    step(1, 1);
    check("lock_in_sync", 32'(in_sync), 32'd1);
    step(1, 2); step(2, 6); step(3, 3); step(4, 4); step(5, 3);
    run_loop(); run_loop(); run_loop();
    check("loops_cycle_count", 32'(cycle_count), 32'd3);
    check("loops_model_cc", 32'(m_cc), 32'd3);
    check("loops_fault_any", 32'(fault_any), 32'd0);

    // Phase 2 shortened to 5 cycles.
    step(0, 8); step(1, 3); step(2, 5); step(3, 1);
    check("short_fault_timing", 32'(fault_timing), 32'd1);
    check("short_in_sync", 32'(in_sync), 32'd1);
    step(3, 2); step(4, 4); step(5, 3);

    // Phase 4 overstays: flag on its 5th sample.
    step_raw(PAT[0], 1'b1);
    check("clr_fault_any", 32'(fault_any), 32'd0);
    step(0, 7); step(1, 3); step(2, 6); step(3, 3); step(4, 4);
    check("p4_on_time", 32'(fault_timing), 32'd0);
    step(4, 1);
    check("overstay_fault_timing", 32'(fault_timing), 32'd1);
    check("overstay_dwell", 32'(dwell), 32'd5);
    step(4, 1); step(5, 3);

    // Skip from phase 0 to phase 2.
    step_raw(PAT[0], 1'b1);
    step(0, 2);
    step(2, 1);
    check("skip_fault_sequence", 32'(fault_sequence), 32'd1);
    check("skip_in_sync", 32'(in_sync), 32'd0);
    step(2, 5);
    step(3, 1);
    check("relock_in_sync", 32'(in_sync), 32'd1);
    step(3, 2); step(4, 4); step(5, 3);

    // Two bits lit on the side road for one cycle, then a clear.
    step_raw(12'b001_001_100_011, 1'b0);
    check("bad_phase", 32'(phase), 32'd7);
    check("bad_fault_pattern", 32'(fault_pattern), 32'd1);
    check("bad_in_sync", 32'(in_sync), 32'd0);
    step_raw(PAT[0], 1'b1);
    check("bad_clr_fault_any", 32'(fault_any), 32'd0);

    // Reset mid-phase 3, then re-sync and a stuck light.
    step(0, 7); step(1, 3); step(2, 6); step(3, 1);
    check("pre_rst_phase", 32'(phase), 32'd3);
    async_reset();
    step(3, 2); step(4, 1);
    check("post_rst_in_sync", 32'(in_sync), 32'd1);
    step(4, 3); step(5, 3); step(0, 8); step(1, 3); step(2, 260);
    check("stuck_dwell_sat", 32'(dwell), 32'd255);
    step(3, 3); step(4, 4); step(5, 3);

    // Randomized phase stream with occasional skips, bad patterns, clears and resets.
    cur = 5;
    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 75) cur = (cur + 1) % 6;
      else if (r < 90) cur = $urandom_range(0, 5);
      else cur = -1;
      if (cur < 0) len = 1;
      else if ($urandom_range(0, 3) != 0) len = DW[cur];
      else len = $urandom_range(1, DW[cur] + 2);
      for (int k = 0; k < len; k++) begin
        v = (cur < 0) ? 12'($urandom) : PAT[cur];
        step_raw(v, 1'($urandom_range(0, 24) == 0));
      end
      if (cur < 0) cur = 5;
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
